// File: rtl/relu_backward_layer.sv
// relu_backward_layer: registered per-lane ReLU/leaky-ReLU derivative of IEEE-754 single vectors
module relu_backward_layer #(
    parameter int  WIDTH          = 8,
    parameter real NEGATIVE_SLOPE = 0.0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id,
    input  logic [31:0] in_vec  [WIDTH-1:0],
    output logic [31:0] out_vec [WIDTH-1:0]
);
    function automatic logic [31:0] real_to_single(input real r);
        logic [63:0] d, mm, kept, mag;
        int ue, sh;
        logic g, s;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, (d[51:0] != 52'h0) ? 23'h40_0000 : 23'h0};
        if (d[62:52] == 11'h0) return {d[63], 31'h0};
        ue = int'(d[62:52]) - 896;
        if (ue >= 255) return {d[63], 31'h7F80_0000};
        // Subnormal results shift further right; the hidden bit then lands in the mantissa field.
        sh = (ue > 0) ? 29 : 30 - ue;
        if (sh > 54) return {d[63], 31'h0};
        mm = {11'h0, 1'b1, d[51:0]};
        kept = mm >> sh;
        g = mm[sh-1];
        s = (mm & ((64'h1 << (sh - 1)) - 64'h1)) != 64'h0;
        if (g && (s || kept[0])) kept = kept + 64'h1;
        mag = ((ue > 0) ? (64'(ue - 1) << 23) : 64'h0) + kept;
        return {d[63], (mag >= 64'h7F80_0000) ? 31'h7F80_0000 : mag[30:0]};
    endfunction

    localparam logic [31:0] SLOPE_BITS = real_to_single(NEGATIVE_SLOPE);
    localparam logic [31:0] ONE_BITS   = 32'h3F80_0000;

    logic [31:0] out_d [WIDTH-1:0];
    logic [31:0] out_q [WIDTH-1:0];
    logic        id_unused;

    assign id_unused = ^id;

    // Positive means sign clear, not +0 and not NaN; +inf still counts as positive.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            out_d[i] = (!in_vec[i][31] && in_vec[i][30:0] != 31'h0 &&
                        !(in_vec[i][30:23] == 8'hFF && in_vec[i][22:0] != 23'h0)) ? ONE_BITS : SLOPE_BITS;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_q <= '{default: 32'h0};
        else        out_q <= out_d;
    end

    assign out_vec = out_q;
endmodule

// File: tb/tb_relu_backward_layer.sv
// tb_relu_backward_layer: directed and random checks of the ReLU derivative stage at slopes 0.0 and 0.01
module tb_relu_backward_layer;
    localparam int W = 8;
    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] LEAKY = 32'h3C23_D70A;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id = 32'h0000_0007;
    logic [31:0] in_vec [W-1:0];
    logic [31:0] out0   [W-1:0];
    logic [31:0] out1   [W-1:0];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    relu_backward_layer #(.WIDTH(W), .NEGATIVE_SLOPE(0.0)) dut0 (
        .clk(clk), .reset(reset), .id(id), .in_vec(in_vec), .out_vec(out0)
    );
    relu_backward_layer #(.WIDTH(W), .NEGATIVE_SLOPE(0.01)) dut1 (
        .clk(clk), .reset(reset), .id(id), .in_vec(in_vec), .out_vec(out1)
    );

    // Golden: positive iff sign clear and magnitude in (0, +inf].
    function automatic logic [31:0] golden(input logic [31:0] x, input logic [31:0] slope);
        return (x[31] == 1'b0 && x[30:0] != 31'h0 && x[30:0] <= 31'h7F80_0000) ? ONE : slope;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < W; i++) in_vec[i] = 32'h4000_0000;
        #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== 32'h0 || out1[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset lane %0d: got %h/%h expected 00000000", i, out0[i], out1[i]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_positive();
        logic [31:0] v [W-1:0];
        v = '{32'h3F80_0000, 32'h4120_0000, 32'h0000_0001, 32'h7F80_0000,
              32'h007F_FFFF, 32'h7F7F_FFFF, 32'h4049_0FDB, 32'h0080_0000};
        in_vec = v;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== ONE || out1[i] !== ONE) begin
                errors++;
                $display("FAIL positive lane %0d in %h: got %h/%h expected %h", i, v[i], out0[i], out1[i], ONE);
            end
        end
    endtask

    task automatic test_nonpositive();
        logic [31:0] v [W-1:0];
        v = '{32'hBF80_0000, 32'h0000_0000, 32'h8000_0000, 32'hFF80_0000,
              32'h7FC0_0000, 32'h7F80_0001, 32'h8000_0001, 32'hFFFF_FFFF};
        @(negedge clk);
        in_vec = v;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== 32'h0 || out1[i] !== LEAKY) begin
                errors++;
                $display("FAIL nonpositive lane %0d in %h: got %h/%h expected 00000000/%h", i, v[i], out0[i], out1[i], LEAKY);
            end
        end
    endtask

    task automatic test_leaky_mixed();
        logic [31:0] v  [W-1:0];
        logic [31:0] e0 [W-1:0];
        logic [31:0] e1 [W-1:0];
        v  = '{32'hC000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h0000_0001,
               32'hFFC0_0000, 32'h7F80_0000, 32'hBF80_0000, 32'h42C8_0000};
        e0 = '{32'h0, ONE, 32'h0, ONE, 32'h0, ONE, 32'h0, ONE};
        e1 = '{LEAKY, ONE, LEAKY, ONE, LEAKY, ONE, LEAKY, ONE};
        @(negedge clk);
        in_vec = v;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== e0[i] || out1[i] !== e1[i]) begin
                errors++;
                $display("FAIL mixed lane %0d in %h: got %h/%h expected %h/%h", i, v[i], out0[i], out1[i], e0[i], e1[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] a [W-1:0];
        @(negedge clk);
        for (int i = 0; i < W; i++) in_vec[i] = 32'h4000_0000 + 32'(i);
        a = in_vec;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) in_vec[i] = 32'hC000_0000 + 32'(i);
        #2;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== golden(a[i], 32'h0) || out1[i] !== golden(a[i], LEAKY)) begin
                errors++;
                $display("FAIL hold lane %0d: got %h/%h expected %h", i, out0[i], out1[i], ONE);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== 32'h0 || out1[i] !== LEAKY) begin
                errors++;
                $display("FAIL hold_update lane %0d: got %h/%h expected 00000000/%h", i, out0[i], out1[i], LEAKY);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sp [8];
        logic [31:0] v  [W-1:0];
        int bad;
        sp = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
               32'h7FC0_0000, 32'h0000_0001, 32'h8000_0001, 32'h7F80_0001};
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            for (int i = 0; i < W; i++)
                in_vec[i] = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 7)] : $urandom;
            v = in_vec;
            @(posedge clk); #1;
            bad = 0;
            for (int i = 0; i < W; i++)
                if (out0[i] !== golden(v[i], 32'h0) || out1[i] !== golden(v[i], LEAKY)) begin
                    if (bad == 0)
                        $display("FAIL stream vec %0d lane %0d in %h: got %h/%h expected %h/%h", n, i, v[i],
                                 out0[i], out1[i], golden(v[i], 32'h0), golden(v[i], LEAKY));
                    bad++;
                end
            checks++;
            if (bad != 0) errors++;
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        for (int i = 0; i < W; i++) in_vec[i] = 32'h3F80_0000;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== 32'h0 || out1[i] !== 32'h0) begin
                errors++;
                $display("FAIL midreset lane %0d: got %h/%h expected 00000000", i, out0[i], out1[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out0[0] !== 32'h0 || out1[W-1] !== 32'h0) begin
            errors++;
            $display("FAIL midreset_held: got %h/%h expected 00000000", out0[0], out1[W-1]);
        end
        @(negedge clk);
        for (int i = 0; i < W; i++) in_vec[i] = (i % 2 == 0) ? 32'hBF80_0000 : 32'h4080_0000;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (out0[i] !== ((i % 2 == 0) ? 32'h0 : ONE) || out1[i] !== ((i % 2 == 0) ? LEAKY : ONE)) begin
                errors++;
                $display("FAIL release lane %0d: got %h/%h", i, out0[i], out1[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_nonpositive();
        test_leaky_mixed();
        test_hold();
        test_back_to_back();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
